split_stream: RTL and testbench

Parametrised stream splitter: accepts one wide word of LANES lane fields and emits the enabled lanes one at a time on a narrow valid/ready output, with lane index and last-beat flag. It generalises the fixed 4-bit bit splitter into a flow-controlled, masked, width- and count-parametrised serialiser. It sits between wide-bus producers and per-lane narrow consumers in the datapath.

---
 rtl/split_stream.sv | 167 ++++++++++++++++
 tb/tb_split_stream.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/split_stream.sv
// ---------------------------------------------------------------------------
// split_stream
//
// Purpose:
//   Serialises one wide input word made of LANES lane fields (each LANE_W
//   bits) into a narrow valid/ready stream, one enabled lane per beat.
//   A per-word mask selects which lanes are emitted. Each beat carries the
//   lane index and a last-beat flag. Words whose mask is all zero are
//   consumed and dropped without producing a beat.
//
// Build option:
//   SPLIT_MSB_FIRST_EN - when defined, lanes are emitted in descending index
//                        order (highest set mask bit first). When undefined,
//                        lanes are emitted in ascending order (lane 0 first).
//
// Parameters:
//   LANES   number of lane fields per input word (2..64)
//   LANE_W  width of each lane field in bits (1..64)
//   IDX_W   lane index width, derived from LANES
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   s_data   in   input word, lane i at [i*LANE_W +: LANE_W]
//   s_mask   in   per-lane emit enable, sampled with s_data
//   s_valid  in   input word valid
//   s_ready  out  splitter can accept a word this cycle
//   m_data   out  current lane field
//   m_lane   out  index of the lane on m_data
//   m_last   out  current beat is the final enabled lane of its word
//   m_valid  out  output beat valid
//   m_ready  in   downstream accepts the beat
// ---------------------------------------------------------------------------
module split_stream #(
    parameter int  LANES  = 4,
    parameter int  LANE_W = 1,
    localparam int IDX_W  = $clog2(LANES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [LANES*LANE_W-1:0] s_data,
    input  logic [LANES-1:0]        s_mask,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [LANE_W-1:0]       m_data,
    output logic [IDX_W-1:0]        m_lane,
    output logic                    m_last,
    output logic                    m_valid,
    input  logic                    m_ready
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t                    state_q;
    logic [LANES*LANE_W-1:0]   word_q;
    // Lanes of the held word that are still to be emitted after the current
    // beat. The current lane is already removed from it.
    logic [LANES-1:0]          pend_q;
    logic [IDX_W-1:0]          lane_q;
    logic [LANE_W-1:0]         data_q;
    logic                      last_q;
    logic                      valid_q;

    // First lane in emit order among the set bits of m (0 when m is empty).
    function automatic logic [IDX_W-1:0] first_lane(input logic [LANES-1:0] m);
        logic [IDX_W-1:0] idx;
        idx = '0;
`ifdef SPLIT_MSB_FIRST_EN
        // Ascending scan: the highest set bit is written last and wins.
        for (int i = 0; i < LANES; i++) begin
            if (m[i]) idx = IDX_W'(i);
        end
`else
        // Descending scan: the lowest set bit is written last and wins.
        for (int i = LANES - 1; i >= 0; i--) begin
            if (m[i]) idx = IDX_W'(i);
        end
`endif
        return idx;
    endfunction

    function automatic logic [LANES-1:0] lane_bit(input logic [IDX_W-1:0] l);
        return LANES'(1) << l;
    endfunction

    // Lane views of the incoming word and the held word.
    logic [LANE_W-1:0] s_lane_w    [LANES];
    logic [LANE_W-1:0] word_lane_w [LANES];

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lanes
        assign s_lane_w[gi]    = s_data[gi*LANE_W +: LANE_W];
        assign word_lane_w[gi] = word_q[gi*LANE_W +: LANE_W];
    end

    // First beat of a freshly loaded word and the lanes left behind it.
    logic [IDX_W-1:0] load_lane_d;
    logic [LANES-1:0] load_rest_d;
    // Next beat of the held word and the lanes left behind it.
    logic [IDX_W-1:0] adv_lane_d;
    logic [LANES-1:0] adv_rest_d;

    assign load_lane_d = first_lane(s_mask);
    assign load_rest_d = s_mask & ~lane_bit(load_lane_d);
    assign adv_lane_d  = first_lane(pend_q);
    assign adv_rest_d  = pend_q & ~lane_bit(adv_lane_d);

    // Ready in IDLE, or on the final beat of a word as it is being taken so
    // the next word can follow with no bubble.
    assign s_ready = (state_q == IDLE) || (m_ready && last_q);

    logic in_hs;
    logic beat_hs;

    assign in_hs   = s_valid && s_ready;
    assign beat_hs = valid_q && m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            pend_q  <= '0;
            lane_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (in_hs) begin
            // Covers both a load from IDLE and a load on the last-beat
            // handshake; in the latter case the old word is finished here.
            word_q <= s_data;
            if (s_mask != '0) begin
                state_q <= EMIT;
                valid_q <= 1'b1;
                lane_q  <= load_lane_d;
                data_q  <= s_lane_w[load_lane_d];
                last_q  <= (load_rest_d == '0);
                pend_q  <= load_rest_d;
            end else begin
                // Empty mask: the word is consumed without any beat.
                state_q <= IDLE;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
                pend_q  <= '0;
            end
        end else if (beat_hs) begin
            if (last_q) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
                pend_q  <= '0;
            end else begin
                lane_q <= adv_lane_d;
                data_q <= word_lane_w[adv_lane_d];
                last_q <= (adv_rest_d == '0);
                pend_q <= adv_rest_d;
            end
        end
    end

    assign m_data  = data_q;
    assign m_lane  = lane_q;
    assign m_last  = last_q;
    assign m_valid = valid_q;

endmodule

// File: tb/tb_split_stream.sv
module tb_split_stream;

    localparam int LANES  = 4;
    localparam int LANE_W = 8;

    logic        clk;
    logic        rst_n;
    logic [31:0] s_data;
    logic [3:0]  s_mask;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  m_data;
    logic [1:0]  m_lane;
    logic        m_last;
    logic        m_valid;
    logic        m_ready;

    split_stream #(.LANES(LANES), .LANE_W(LANE_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_data  (s_data),
        .s_mask  (s_mask),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_lane  (m_lane),
        .m_last  (m_last),
        .m_valid (m_valid),
        .m_ready (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [1:0] l;
        logic       last;
    } beat_t;

    beat_t sbq[$];
    int    total = 0;
    int    bad   = 0;

    // Values observed in the last driven cycle (sampled just after negedge).
    logic       obs_fire;
    logic       obs_inhs;
    logic [7:0] obs_d;
    logic [1:0] obs_l;
    logic       obs_last;
    logic       obs_sready;
    logic       obs_mvalid;

    // Reference model: expected beats of one accepted word.
    task automatic push_word(input logic [31:0] d, input logic [3:0] m);
        int    order[$];
        beat_t b;
`ifdef SPLIT_MSB_FIRST_EN
        for (int i = 3; i >= 0; i--) if (m[i]) order.push_back(i);
`else
        for (int i = 0; i < 4; i++) if (m[i]) order.push_back(i);
`endif
        for (int k = 0; k < order.size(); k++) begin
            b.d    = d[order[k]*8 +: 8];
            b.l    = 2'(order[k]);
            b.last = (k == order.size() - 1);
            sbq.push_back(b);
        end
    endtask

    // Drive one cycle of inputs, sample outputs, record handshakes.
    task automatic drive(input logic sv, input logic [31:0] d,
                         input logic [3:0] m, input logic mr);
        @(negedge clk);
        s_valid = sv;
        s_data  = d;
        s_mask  = m;
        m_ready = mr;
        #1;
        obs_fire   = m_valid && m_ready;
        obs_inhs   = s_valid && s_ready;
        obs_d      = m_data;
        obs_l      = m_lane;
        obs_last   = m_last;
        obs_sready = s_ready;
        obs_mvalid = m_valid;
        if (obs_inhs) push_word(d, m);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_mask = '0; m_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%0b want=0", m_valid); end
        total++; if (m_data !== 8'h00) begin bad++; $display("FAIL reset_m_data got=%h want=00", m_data); end
        total++; if (m_lane !== 2'd0) begin bad++; $display("FAIL reset_m_lane got=%0d want=0", m_lane); end
        total++; if (m_last !== 1'b0) begin bad++; $display("FAIL reset_m_last got=%0b want=0", m_last); end
        rst_n = 1'b1;
        #1;
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready got=%0b want=1", s_ready); end
        $display("test_reset: outputs checked in and after reset");
    endtask

    // Accept one word then run nbeats cycles with m_ready=1, expecting a beat each cycle.
    task automatic test_word(input string name, input logic [31:0] d, input logic [3:0] m,
                             input int nbeats);
        beat_t e;
        drive(1'b1, d, m, 1'b1);
        total++; if (obs_inhs !== 1'b1) begin bad++; $display("FAIL %s_accept got=%0b want=1", name, obs_inhs); end
        for (int i = 0; i < nbeats; i++) begin
            drive(1'b0, 32'h0, 4'h0, 1'b1);
            total++;
            if (!obs_fire) begin
                bad++; $display("FAIL %s_beat%0d m_valid got=%0b want=1", name, i, obs_mvalid);
            end else if (sbq.size() == 0) begin
                bad++; $display("FAIL %s_beat%0d unexpected beat data=%h lane=%0d", name, i, obs_d, obs_l);
            end else begin
                e = sbq.pop_front();
                if (obs_d !== e.d || obs_l !== e.l || obs_last !== e.last || obs_sready !== e.last) begin
                    bad++;
                    $display("FAIL %s_beat%0d got d=%h l=%0d last=%0b s_ready=%0b want d=%h l=%0d last=%0b s_ready=%0b",
                             name, i, obs_d, obs_l, obs_last, obs_sready, e.d, e.l, e.last, e.last);
                end
            end
            $display("%s beat %0d: data=%h lane=%0d last=%0b", name, i, obs_d, obs_l, obs_last);
        end
        drive(1'b0, 32'h0, 4'h0, 1'b1);
        total++; if (obs_mvalid !== 1'b0) begin bad++; $display("FAIL %s_idle m_valid got=%0b want=0", name, obs_mvalid); end
        total++; if (sbq.size() != 0) begin bad++; $display("FAIL %s_pending got=%0d want=0", name, sbq.size()); end
    endtask

    task automatic test_zero_mask();
        drive(1'b1, 32'hDEADBEEF, 4'b0000, 1'b1);
        total++; if (obs_inhs !== 1'b1) begin bad++; $display("FAIL zero_accept got=%0b want=1", obs_inhs); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 4'h0, 1'b1);
            total++;
            if (obs_mvalid !== 1'b0 || obs_sready !== 1'b1) begin
                bad++; $display("FAIL zero_cycle%0d got m_valid=%0b s_ready=%0b want 0/1", i, obs_mvalid, obs_sready);
            end
        end
        $display("test_zero_mask: word dropped, no beat");
    endtask

    task automatic test_back_to_back();
        beat_t e;
        drive(1'b1, 32'h04030201, 4'b1111, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            // B presented continuously until it is taken on A's final beat.
            drive(i <= 4, 32'h08070605, 4'b1111, 1'b1);
            if (i == 4) begin
                total++; if (obs_inhs !== 1'b1) begin bad++; $display("FAIL b2b_accept_B got=%0b want=1", obs_inhs); end
            end
            total++;
            if (!obs_fire || sbq.size() == 0) begin
                bad++; $display("FAIL b2b_beat%0d m_valid got=%0b want=1 (queue=%0d)", i, obs_mvalid, sbq.size());
            end else begin
                e = sbq.pop_front();
                if (obs_d !== e.d || obs_l !== e.l || obs_last !== e.last) begin
                    bad++; $display("FAIL b2b_beat%0d got d=%h l=%0d last=%0b want d=%h l=%0d last=%0b",
                                    i, obs_d, obs_l, obs_last, e.d, e.l, e.last);
                end
            end
            $display("b2b beat %0d: data=%h lane=%0d last=%0b", i, obs_d, obs_l, obs_last);
        end
        drive(1'b0, 32'h0, 4'h0, 1'b1);
        total++; if (obs_mvalid !== 1'b0 || sbq.size() != 0) begin
            bad++; $display("FAIL b2b_end got m_valid=%0b pending=%0d want 0/0", obs_mvalid, sbq.size());
        end
    endtask

    task automatic test_stall();
        beat_t e;
        drive(1'b1, 32'h44332211, 4'b1111, 1'b1);
        drive(1'b0, 32'h0, 4'h0, 1'b1);
        total++;
        e = sbq.pop_front();
        if (!obs_fire || obs_d !== e.d || obs_l !== e.l) begin
            bad++; $display("FAIL stall_first got d=%h l=%0d want d=%h l=%0d", obs_d, obs_l, e.d, e.l);
        end
        for (int i = 0; i < 5; i++) begin
            // Stalled beat must be the next expected one, held steady.
            drive(1'b1, 32'hAAAAAAAA, 4'b1111, 1'b0);
            e = sbq[0];
            total++;
            if (obs_mvalid !== 1'b1 || obs_d !== e.d || obs_l !== e.l || obs_last !== e.last || obs_sready !== 1'b0) begin
                bad++; $display("FAIL stall_hold%0d got v=%0b d=%h l=%0d last=%0b s_ready=%0b want v=1 d=%h l=%0d last=%0b s_ready=0",
                                i, obs_mvalid, obs_d, obs_l, obs_last, obs_sready, e.d, e.l, e.last);
            end
            $display("stall cycle %0d: data=%h lane=%0d s_ready=%0b", i, obs_d, obs_l, obs_sready);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 4'h0, 1'b1);
            total++;
            if (!obs_fire || sbq.size() == 0) begin
                bad++; $display("FAIL stall_resume%0d m_valid got=%0b want=1", i, obs_mvalid);
            end else begin
                e = sbq.pop_front();
                if (obs_d !== e.d || obs_l !== e.l || obs_last !== e.last) begin
                    bad++; $display("FAIL stall_resume%0d got d=%h l=%0d last=%0b want d=%h l=%0d last=%0b",
                                    i, obs_d, obs_l, obs_last, e.d, e.l, e.last);
                end
            end
        end
        total++; if (sbq.size() != 0) begin bad++; $display("FAIL stall_pending got=%0d want=0", sbq.size()); end
    endtask

    task automatic test_reset_mid();
        beat_t e;
        drive(1'b1, 32'h44332211, 4'b1111, 1'b1);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'h0, 4'h0, 1'b1);
            void'(sbq.pop_front());
        end
        drive(1'b0, 32'h0, 4'h0, 1'b0);
        e = sbq[0];
        total++; if (obs_mvalid !== 1'b1 || obs_l !== e.l) begin
            bad++; $display("FAIL rstmid_pre got v=%0b l=%0d want v=1 l=%0d", obs_mvalid, obs_l, e.l);
        end
        // Assert reset between clock edges: outputs must drop immediately.
        rst_n = 1'b0;
        #1;
        total++; if (m_valid !== 1'b0 || m_last !== 1'b0) begin
            bad++; $display("FAIL rstmid_async got v=%0b last=%0b want 0/0", m_valid, m_last);
        end
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rstmid_s_ready got=%0b want=1", s_ready); end
        $display("test_reset_mid: remaining beats discarded");
    endtask

    initial begin
        test_reset();
        test_word("all", 32'h44332211, 4'b1111, 4);
        test_word("sparse", 32'h44332211, 4'b1010, 2);
        test_word("single", 32'h44332211, 4'b0100, 1);
        test_zero_mask();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_word("after_rst", 32'hD4C3B2A1, 4'b0110, 2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
